// File: rtl/caesar_stream_gen.sv
// caesar_stream_gen: self-stepping plaintext counter feeding a two-stage
// modular shift cipher. Steps come from a prescaler that stalls in HOLD
// while the consumer refuses a pending result.
module caesar_stream_gen #(
  parameter int ALPHA_SIZE = 26,
  parameter int DATA_W     = 6,
  parameter int KEY_W      = 5,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              run,
  input  logic              decrypt,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] plain_out,
  output logic [DATA_W-1:0] cipher_out,
  output logic [DATA_W-1:0] key_out,
  output logic              step_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DATA_W-1:0] SYM_MAX   = DATA_W'(ALPHA_SIZE - 1);
  localparam logic [DATA_W:0]   MODULUS   = (DATA_W + 1)'(ALPHA_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     presc_reg, presc_next;
  logic              presc_max;

  logic [DATA_W-1:0] plain_cnt_reg;
  logic              s1_valid_reg;
  logic [DATA_W-1:0] s1_plain_reg;
  logic [DATA_W-1:0] s1_key_reg;
  logic              s1_dec_reg;

  logic [DATA_W-1:0] key_sat;
  logic [DATA_W:0]   shift_sum;
  logic [DATA_W-1:0] shift_res;

  assign presc_max = (presc_reg == PRESC_MAX);

  // State and prescaler registers
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
    end
  end

  // Next-state: pause always wins; stall into HOLD when a result is still unaccepted
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (run) state_next = RUN;
      RUN: begin
        if (!run)
          state_next = IDLE;
        else if (presc_max && out_valid && !out_ready)
          state_next = HOLD;
      end
      HOLD: begin
        if (!run)
          state_next = IDLE;
        else if (out_ready)
          state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs of the FSM: step pulse and prescaler update
  always_comb begin
    step_tick  = 1'b0;
    presc_next = presc_reg;
    if (run) begin
      if (state_reg == RUN && presc_max && (!out_valid || out_ready))
        step_tick = 1'b1;
      else if (state_reg == HOLD && out_ready)
        step_tick = 1'b1;
    end
    if (!run || state_reg == IDLE)
      presc_next = '0;
    else if (step_tick)
      presc_next = '0;
    else if (state_reg == RUN && !presc_max)
      presc_next = presc_reg + 1'b1;
  end

  // Key saturation is done before capture so stage 2 can rely on k < ALPHA_SIZE
  always_comb begin
    key_sat = DATA_W'(key_in);
    if (32'(key_in) > ALPHA_SIZE - 1)
      key_sat = SYM_MAX;
  end

  // Stage-2 arithmetic: one conditional subtract is enough since p,k < ALPHA_SIZE
  always_comb begin
    shift_sum = s1_dec_reg ? ({1'b0, s1_plain_reg} + MODULUS - {1'b0, s1_key_reg})
                           : ({1'b0, s1_plain_reg} + {1'b0, s1_key_reg});
    shift_res = (shift_sum >= MODULUS) ? DATA_W'(shift_sum - MODULUS)
                                       : DATA_W'(shift_sum);
  end

  // Plain counter, stage-1 capture and output register with valid/ready
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      plain_cnt_reg <= '0;
      s1_valid_reg  <= 1'b0;
      s1_plain_reg  <= '0;
      s1_key_reg    <= '0;
      s1_dec_reg    <= 1'b0;
      out_valid     <= 1'b0;
      plain_out     <= '0;
      cipher_out    <= '0;
      key_out       <= '0;
    end else begin
      s1_valid_reg <= step_tick;
      if (step_tick) begin
        s1_plain_reg  <= plain_cnt_reg;
        s1_key_reg    <= key_sat;
        s1_dec_reg    <= decrypt;
        plain_cnt_reg <= (plain_cnt_reg == SYM_MAX) ? '0 : plain_cnt_reg + 1'b1;
      end
      if (s1_valid_reg) begin
        out_valid  <= 1'b1;
        plain_out  <= s1_plain_reg;
        cipher_out <= shift_res;
        key_out    <= s1_key_reg;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
